// File: rtl/multicycle_ctrl_fsm_if.sv
// Signal bundle between the multi-cycle controller and its datapath/memory port.
// The controller side uses the master modport; the datapath side uses slave.
interface multicycle_ctrl_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       branch_taken;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic [3:0] alu_func;
  logic [1:0] alu_src;

  modport master (
    input  opcode, funct3, funct7b5, branch_taken, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
           wb_sel, alu_func, alu_src
  );

  modport slave (
    output opcode, funct3, funct7b5, branch_taken, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
           wb_sel, alu_func, alu_src
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle processor controller: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// over a shared ALU and memory port, counts retired instructions, flags faults.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  multicycle_ctrl_fsm_if.master ctrl,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_cause,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_ADDI  = 4'b0001;
  localparam logic [3:0] ALU_LOAD  = 4'b0010;
  localparam logic [3:0] ALU_STORE = 4'b0011;
  localparam logic [3:0] ALU_LUI   = 4'b0100;
  localparam logic [3:0] ALU_JAL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_BEQ   = 4'b1000;
  localparam logic [3:0] ALU_SUB   = 4'b1001;

  localparam logic [1:0] SRC_RS2  = 2'd0;
  localparam logic [1:0] SRC_ZEXT = 2'd1;
  localparam logic [1:0] SRC_SEXT = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_LUI, C_JAL, C_BRANCH, C_NONE
  } iclass_t;

  state_t           state, state_nxt;
  iclass_t          iclass, iclass_nxt, dec_class;
  logic             dec_legal;
  logic             f3_alu_ok;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             mem_expired;
  logic             err_nxt;
  logic [1:0]       cause_nxt;
  logic             retire;
  logic [3:0]       class_func;
  logic [1:0]       class_src;

  logic             mem_req_c, mem_we_c, ir_write_c, pc_write_c, pc_src_c, reg_write_c;
  logic [1:0]       wb_sel_c, alu_src_c;
  logic [3:0]       alu_func_c;

  assign f3_alu_ok   = (ctrl.funct3 == 3'b000) || (ctrl.funct3 == 3'b110) ||
                       (ctrl.funct3 == 3'b111);
  assign mem_expired = !ctrl.mem_ready && (wait_cnt == TIMEOUT);

  // Opcode classifier; only meaningful in DECODE when the IR holds the word.
  always_comb begin
    dec_class = C_NONE;
    dec_legal = 1'b0;
    case (ctrl.opcode)
      OP_R: begin
        dec_class = C_R;
        dec_legal = f3_alu_ok && !(ctrl.funct7b5 && (ctrl.funct3 != 3'b000));
      end
      OP_I: begin
        dec_class = C_I;
        dec_legal = f3_alu_ok;
      end
      OP_LOAD: begin
        dec_class = C_LOAD;
        dec_legal = 1'b1;
      end
      OP_STORE: begin
        dec_class = C_STORE;
        dec_legal = 1'b1;
      end
      OP_LUI: begin
        dec_class = C_LUI;
        dec_legal = 1'b1;
      end
      OP_JAL: begin
        dec_class = C_JAL;
        dec_legal = 1'b1;
      end
      OP_BRANCH: begin
        dec_class = C_BRANCH;
        dec_legal = (ctrl.funct3 == 3'b000);
      end
      default: begin
        dec_class = C_NONE;
        dec_legal = 1'b0;
      end
    endcase
  end

  // ALU control per latched class; funct bits still come from the held IR.
  always_comb begin
    class_func = ALU_ADD;
    class_src  = SRC_RS2;
    case (iclass)
      C_R: begin
        class_src = SRC_RS2;
        case (ctrl.funct3)
          3'b110:  class_func = ALU_OR;
          3'b111:  class_func = ALU_AND;
          default: class_func = ctrl.funct7b5 ? ALU_SUB : ALU_ADD;
        endcase
      end
      C_I: begin
        class_src = SRC_SEXT;
        case (ctrl.funct3)
          3'b110:  class_func = ALU_OR;
          3'b111:  class_func = ALU_AND;
          default: class_func = ALU_ADDI;
        endcase
      end
      C_LOAD: begin
        class_func = ALU_LOAD;
        class_src  = SRC_SEXT;
      end
      C_STORE: begin
        class_func = ALU_STORE;
        class_src  = SRC_SEXT;
      end
      C_LUI: begin
        class_func = ALU_LUI;
        class_src  = SRC_ZEXT;
      end
      C_JAL: begin
        class_func = ALU_JAL;
        class_src  = SRC_SEXT;
      end
      C_BRANCH: begin
        class_func = ALU_BEQ;
        class_src  = SRC_RS2;
      end
      default: begin
        class_func = ALU_ADD;
        class_src  = SRC_RS2;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      iclass      <= C_NONE;
      wait_cnt    <= 8'd0;
      err         <= 1'b0;
      err_cause   <= 2'd0;
      instr_count <= '0;
    end else begin
      state     <= state_nxt;
      iclass    <= iclass_nxt;
      wait_cnt  <= wait_nxt;
      err       <= err_nxt;
      err_cause <= cause_nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next-state and outputs. The wait counter defaults to zero so it is cleared
  // whenever FETCH or MEM is entered and only advances while a request stalls.
  // The fetch strobes are qualified by mem_ready so a zero-wait fetch takes one cycle.
  always_comb begin
    state_nxt   = state;
    iclass_nxt  = iclass;
    wait_nxt    = 8'd0;
    err_nxt     = err;
    cause_nxt   = err_cause;
    retire      = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 1'b0;
    reg_write_c = 1'b0;
    wb_sel_c    = WB_ALU;
    alu_func_c  = ALU_ADD;
    alu_src_c   = SRC_RS2;
    busy        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end

      S_FETCH: begin
        busy      = 1'b1;
        mem_req_c = 1'b1;
        if (ctrl.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_nxt  = S_DECODE;
        end else if (mem_expired) begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        if (dec_legal) begin
          iclass_nxt = dec_class;
          state_nxt  = S_EXECUTE;
        end else begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end

      S_EXECUTE: begin
        busy       = 1'b1;
        alu_func_c = class_func;
        alu_src_c  = class_src;
        case (iclass)
          C_R, C_I, C_LUI: state_nxt = S_WRITEBACK;
          C_LOAD, C_STORE: state_nxt = S_MEM;
          C_JAL: begin
            pc_write_c = 1'b1;
            pc_src_c   = 1'b1;
            state_nxt  = S_WRITEBACK;
          end
          C_BRANCH: begin
            pc_write_c = ctrl.branch_taken;
            pc_src_c   = 1'b1;
            retire     = 1'b1;
            state_nxt  = S_FETCH;
          end
          default: begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        busy       = 1'b1;
        alu_func_c = class_func;
        alu_src_c  = class_src;
        mem_req_c  = 1'b1;
        mem_we_c   = (iclass == C_STORE);
        if (ctrl.mem_ready) begin
          if (iclass == C_STORE) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (mem_expired) begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end

      S_WRITEBACK: begin
        busy        = 1'b1;
        alu_func_c  = class_func;
        alu_src_c   = class_src;
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_nxt   = S_FETCH;
        if (iclass == C_LOAD)     wb_sel_c = WB_MEM;
        else if (iclass == C_JAL) wb_sel_c = WB_PC4;
        else                      wb_sel_c = WB_ALU;
      end

      S_ERROR: begin
        state_nxt = S_ERROR;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign ctrl.mem_req   = mem_req_c;
  assign ctrl.mem_we    = mem_we_c;
  assign ctrl.ir_write  = ir_write_c;
  assign ctrl.pc_write  = pc_write_c;
  assign ctrl.pc_src    = pc_src_c;
  assign ctrl.reg_write = reg_write_c;
  assign ctrl.wb_sel    = wb_sel_c;
  assign ctrl.alu_func  = alu_func_c;
  assign ctrl.alu_src   = alu_src_c;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle stimulus and expected
// outputs are queued together, then replayed and compared cycle by cycle.
module tb_multicycle_ctrl_fsm;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BR     = 7'b1100011;

  typedef struct packed {
    logic       busy;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [3:0] alu_func;
    logic [1:0] alu_src;
    logic       err;
    logic [1:0] err_cause;
  } outs_t;

  typedef struct {
    logic             start;
    logic             mem_ready;
    logic [6:0]       op;
    logic [2:0]       f3;
    logic             f7;
    logic             bt;
    outs_t            exp;
    logic [CNT_W-1:0] cnt;
    int               idx;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, err;
  logic [1:0] err_cause;
  logic [CNT_W-1:0] instr_count;

  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ctrl        (bus),
    .busy        (busy),
    .err         (err),
    .err_cause   (err_cause),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  step_t            sb[$];
  int               checks   = 0;
  int               failures = 0;
  int               step_no  = 0;
  logic [CNT_W-1:0] model_count = '0;
  logic [6:0]       cur_op = '0;
  logic [2:0]       cur_f3 = '0;
  logic             cur_f7 = 1'b0;
  logic             cur_bt = 1'b0;

  function automatic outs_t observe();
    outs_t o;
    o.busy      = busy;
    o.mem_req   = bus.mem_req;
    o.mem_we    = bus.mem_we;
    o.ir_write  = bus.ir_write;
    o.pc_write  = bus.pc_write;
    o.pc_src    = bus.pc_src;
    o.reg_write = bus.reg_write;
    o.wb_sel    = bus.wb_sel;
    o.alu_func  = bus.alu_func;
    o.alu_src   = bus.alu_src;
    o.err       = err;
    o.err_cause = err_cause;
    return o;
  endfunction

  function automatic void push(input logic st, input logic mr, input outs_t o);
    step_t e;
    e.start = st; e.mem_ready = mr;
    e.op = cur_op; e.f3 = cur_f3; e.f7 = cur_f7; e.bt = cur_bt;
    e.exp = o; e.cnt = model_count; e.idx = step_no;
    step_no++;
    sb.push_back(e);
  endfunction

  function automatic void push_idle_start();
    push(1'b1, 1'b0, outs_t'('0));
  endfunction

  function automatic void push_fetch_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7, input int fwait);
    outs_t o;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_bt = 1'b0;
    for (int i = 0; i < fwait; i++) begin
      o = '0; o.busy = 1'b1; o.mem_req = 1'b1;
      push(1'b0, 1'b0, o);
    end
    o = '0; o.busy = 1'b1; o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(1'b0, 1'b1, o);
    o = '0; o.busy = 1'b1;
    push(1'b0, 1'b1, o);
  endfunction

  // Whole legal instruction; mem_ready is driven high outside memory waits on purpose.
  function automatic void push_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     input logic bt, input int fwait, input int mwait,
                                     input logic [3:0] af, input logic [1:0] as);
    outs_t o;
    push_fetch_decode(op, f3, f7, fwait);
    cur_bt = bt;
    o = '0; o.busy = 1'b1; o.alu_func = af; o.alu_src = as;
    if (op == OP_BR) begin
      o.pc_write = bt; o.pc_src = 1'b1;
      push(1'b0, 1'b1, o);
      model_count++;
      return;
    end
    if (op == OP_JAL) begin o.pc_write = 1'b1; o.pc_src = 1'b1; end
    push(1'b0, 1'b1, o);
    o.pc_write = 1'b0; o.pc_src = 1'b0;
    if (op == OP_LOAD || op == OP_STORE) begin
      o.mem_req = 1'b1; o.mem_we = (op == OP_STORE);
      for (int i = 0; i < mwait; i++) push(1'b0, 1'b0, o);
      push(1'b0, 1'b1, o);
      if (op == OP_STORE) begin model_count++; return; end
      o.mem_req = 1'b0; o.mem_we = 1'b0;
    end
    o.reg_write = 1'b1;
    o.wb_sel = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL) ? 2'd2 : 2'd0;
    push(1'b0, 1'b1, o);
    model_count++;
  endfunction

  function automatic void push_error_cycles(input logic [1:0] cause, input int n);
    outs_t o;
    o = '0; o.err = 1'b1; o.err_cause = cause;
    for (int i = 0; i < n; i++) push(i[0], 1'b1, o);
  endfunction

  // Replays one queued cycle: drive after the edge, sample at the falling edge.
  task automatic step_dut(output step_t e, output outs_t o, output logic [CNT_W-1:0] c);
    e = sb.pop_front();
    start            = e.start;
    bus.mem_ready    = e.mem_ready;
    bus.opcode       = e.op;
    bus.funct3       = e.f3;
    bus.funct7b5     = e.f7;
    bus.branch_taken = e.bt;
    @(negedge clk);
    o = observe();
    c = instr_count;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_count = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    rst_n = 1'b1; start = 1'b0; bus.mem_ready = 1'b0; bus.opcode = '0;
    bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.branch_taken = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (observe() !== outs_t'('0) || instr_count !== '0) begin
      failures++;
      $display("[TB] FAIL reset_async outs=%h count=%0d required outs=0 count=0", observe(), instr_count);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    model_count = '0;
    push(1'b0, 1'b1, outs_t'('0));
    push(1'b0, 1'b0, outs_t'('0));
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL reset_idle step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
  endtask

  task automatic test_add();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    push_idle_start();
    push_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 4'b0000, 2'b00);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL add step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
  endtask

  task automatic test_alu_ops();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    push_instr(OP_R,     3'b000, 1'b1, 1'b0, 0, 0, 4'b1001, 2'b00);
    push_instr(OP_R,     3'b110, 1'b0, 1'b0, 2, 0, 4'b0110, 2'b00);
    push_instr(OP_R,     3'b111, 1'b0, 1'b0, 0, 0, 4'b0111, 2'b00);
    push_instr(OP_I,     3'b000, 1'b1, 1'b0, 0, 0, 4'b0001, 2'b10);
    push_instr(OP_I,     3'b110, 1'b0, 1'b0, 0, 0, 4'b0110, 2'b10);
    push_instr(OP_I,     3'b111, 1'b0, 1'b0, 1, 0, 4'b0111, 2'b10);
    push_instr(OP_LUI,   3'b101, 1'b0, 1'b0, 0, 0, 4'b0100, 2'b01);
    push_instr(OP_JAL,   3'b000, 1'b0, 1'b0, 0, 0, 4'b0101, 2'b10);
    push_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 0, 4'b0011, 2'b10);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL alu_ops step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
  endtask

  task automatic test_load();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    push_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 3, 4'b0010, 2'b10);
    push_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 0, 4'b0010, 2'b10);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL load step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    push_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, 4'b1000, 2'b00);
    push_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0, 4'b1000, 2'b00);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL branch step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
  endtask

  // A response on the last permitted wait cycle still completes the request.
  task automatic test_mem_boundary();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    push_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 0, MEM_TIMEOUT, 4'b0011, 2'b10);
    push_instr(OP_LOAD,  3'b010, 1'b0, 1'b0, MEM_TIMEOUT, 1, 4'b0010, 2'b10);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL mem_boundary step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    while (model_count != '1) push_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0, 4'b1000, 2'b00);
    push_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, 4'b1000, 2'b00);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL wrap step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
    checks++;
    if (instr_count !== '0) begin
      failures++;
      $display("[TB] FAIL wrap_zero count=%0d required=0", instr_count);
    end
  endtask

  task automatic test_reset_mid_mem();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    push_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 4'b0000, 2'b00);
    push_fetch_decode(OP_LOAD, 3'b010, 1'b0, 0);
    o = '0; o.busy = 1'b1; o.alu_func = 4'b0010; o.alu_src = 2'b10;
    push(1'b0, 1'b1, o);
    o.mem_req = 1'b1;
    push(1'b0, 1'b0, o);
    push(1'b0, 1'b0, o);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL mid_mem_pre step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
    bus.mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observe() !== outs_t'('0) || instr_count !== '0) begin
      failures++;
      $display("[TB] FAIL mid_mem_reset outs=%h count=%0d required outs=0 count=0", observe(), instr_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_count = '0;
    push(1'b0, 1'b1, outs_t'('0));
    push_idle_start();
    push_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0, 4'b1000, 2'b00);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL mid_mem_restart step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
  endtask

  task automatic test_illegal();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    logic [10:0] bad [5];
    bad[0] = {7'b1111111, 3'b000, 1'b0};
    bad[1] = {OP_R,       3'b001, 1'b0};
    bad[2] = {OP_R,       3'b110, 1'b1};
    bad[3] = {OP_BR,      3'b001, 1'b0};
    bad[4] = {OP_I,       3'b010, 1'b0};
    for (int k = 0; k < 5; k++) begin
      apply_reset();
      push_idle_start();
      push_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 4'b0000, 2'b00);
      push_fetch_decode(bad[k][10:4], bad[k][3:1], bad[k][0], 0);
      push_error_cycles(2'd1, 3);
      while (sb.size() > 0) begin
        step_dut(e, o, c);
        checks++;
        if (o !== e.exp || c !== e.cnt) begin
          failures++;
          $display("[TB] FAIL illegal%0d step%0d outs=%h exp=%h count=%0d exp=%0d", k, e.idx, o, e.exp, c, e.cnt);
        end
      end
    end
  endtask

  task automatic test_timeout();
    outs_t o; step_t e; logic [CNT_W-1:0] c;
    apply_reset();
    push_idle_start();
    push_fetch_decode(OP_STORE, 3'b010, 1'b0, 0);
    o = '0; o.busy = 1'b1; o.alu_func = 4'b0011; o.alu_src = 2'b10;
    push(1'b0, 1'b1, o);
    o.mem_req = 1'b1; o.mem_we = 1'b1;
    for (int i = 0; i <= MEM_TIMEOUT; i++) push(1'b0, 1'b0, o);
    push_error_cycles(2'd2, 4);
    while (sb.size() > 0) begin
      step_dut(e, o, c);
      checks++;
      if (o !== e.exp || c !== e.cnt) begin
        failures++;
        $display("[TB] FAIL timeout step%0d outs=%h exp=%h count=%0d exp=%0d", e.idx, o, e.exp, c, e.cnt);
      end
    end
    apply_reset();
    #2;
    checks++;
    if (err !== 1'b0 || err_cause !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_clear err=%b cause=%0d busy=%b required 0/0/0", err, err_cause, busy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_load();
    test_branch();
    test_mem_boundary();
    test_wrap();
    test_reset_mid_mem();
    test_illegal();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
